// File: rtl/ahb2apb_bridge.sv
// ahb2apb_bridge: AHB-Lite slave to single-segment APB master bridge.
// Each accepted AHB single transfer becomes one APB SETUP/ACCESS pair; the AHB
// data phase is stretched with hready_out until the APB slave completes.
// Optional build macro: AHB2APB_TIMEOUT_EN aborts an ACCESS phase that sees no
// pready for TIMEOUT_CYCLES cycles and answers with an AHB ERROR response.
`timescale 1ns/1ps
module ahb2apb_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  hclk,
  input  logic                  hreset_n,
  // AHB-Lite slave side
  input  logic                  hsel,
  input  logic [1:0]            htrans,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic                  hwrite,
  input  logic [DATA_WIDTH-1:0] hwdata,
  input  logic                  hready_in,
  output logic                  hready_out,
  output logic                  hresp,
  output logic [DATA_WIDTH-1:0] hrdata,
  // APB master side
  output logic                  psel,
  output logic                  penable,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  pwrite,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LATCH  = 3'd1,
    S_SETUP  = 3'd2,
    S_ACCESS = 3'd3,
    S_ERR1   = 3'd4,
    S_ERR2   = 3'd5,
    S_RESP   = 3'd6
  } state_t;

  // Captured AHB address-phase request, presented on the APB side.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  write;
  } apb_req_t;

  state_t   state, state_nxt;
  apb_req_t req_q;
  logic     ready_st;
  logic     accept;
  logic     timeout;

  // hready_out is a pure state decode so accept never loops back through it.
  assign ready_st   = (state == S_IDLE) || (state == S_RESP) || (state == S_ERR2);
  assign hready_out = ready_st;

  // SEQ is treated like NONSEQ: bursts arrive here as a string of singles.
  assign accept = hsel & hready_in & ready_st & (htrans inside {2'b10, 2'b11});

  assign paddr  = req_q.addr;
  assign pwrite = req_q.write;

`ifdef AHB2APB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;

  // Count ACCESS cycles without pready; cleared whenever ACCESS is not active.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n)                 to_cnt <= '0;
    else if (state != S_ACCESS)    to_cnt <= '0;
    else if (!pready)              to_cnt <= to_cnt + 1'b1;
  end

  // Fires on the last allowed waiting ACCESS cycle.
  assign timeout = (state == S_ACCESS) && !pready && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) state <= S_IDLE;
    else           state <= state_nxt;
  end

  // Next-state and APB/AHB control decode.
  always_comb begin
    state_nxt = state;
    psel      = 1'b0;
    penable   = 1'b0;
    hresp     = 1'b0;
    case (state)
      S_IDLE:   if (accept) state_nxt = S_LATCH;
      S_LATCH:  state_nxt = S_SETUP;
      S_SETUP: begin
        psel      = 1'b1;
        state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (pready)       state_nxt = pslverr ? S_ERR1 : S_RESP;
        else if (timeout) state_nxt = S_ERR1;
      end
      S_ERR1: begin
        hresp     = 1'b1;
        state_nxt = S_ERR2;
      end
      S_ERR2: begin
        hresp     = 1'b1;
        state_nxt = accept ? S_LATCH : S_IDLE;
      end
      S_RESP:   state_nxt = accept ? S_LATCH : S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Request, write-data and read-data capture; all held while ACCESS waits.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      req_q  <= '0;
      pwdata <= '0;
      hrdata <= '0;
    end else begin
      if (accept) begin
        req_q.addr  <= haddr;
        req_q.write <= hwrite;
      end
      // hwdata is valid in the first data-phase cycle; reads keep old pwdata.
      if (state == S_LATCH && req_q.write) pwdata <= hwdata;
      // Only a clean read completion updates hrdata.
      if (state == S_ACCESS && pready && !pslverr && !req_q.write) hrdata <= prdata;
    end
  end

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Bench for ahb2apb_bridge: directed protocol steps followed by randomized
// transfers, checked against a transaction-level expectation of the APB trace.
`timescale 1ns/1ps
module tb_ahb2apb_bridge;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          hclk, hreset_n;
  logic          hsel, hwrite, hready_in;
  logic [1:0]    htrans;
  logic [AW-1:0] haddr, paddr;
  logic [DW-1:0] hwdata, hrdata, pwdata, prdata;
  logic          hready_out, hresp, psel, penable, pwrite, pready, pslverr;

  ahb2apb_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
    .hclk(hclk), .hreset_n(hreset_n),
    .hsel(hsel), .htrans(htrans), .haddr(haddr), .hwrite(hwrite), .hwdata(hwdata),
    .hready_in(hready_in), .hready_out(hready_out), .hresp(hresp), .hrdata(hrdata),
    .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  initial hclk = 1'b0;
  always #10 hclk = ~hclk;

  typedef struct {
    logic [AW-1:0] a;
    logic          w;
    logic [DW-1:0] wd;
    int            waits;
    logic          err;
    logic [DW-1:0] rd;
    bit            b2b;
  } xfer_t;

  int checks = 0;
  int errors = 0;

  // Transaction-level model state: last written data and last good read data.
  logic [DW-1:0] last_wd;
  logic [DW-1:0] exp_hrdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic e_sel, input logic e_en,
                         input logic e_rdy, input logic e_resp);
    chk({tag, ".psel"},       64'(psel),       64'(e_sel));
    chk({tag, ".penable"},    64'(penable),    64'(e_en));
    chk({tag, ".hready_out"}, 64'(hready_out), 64'(e_rdy));
    chk({tag, ".hresp"},      64'(hresp),      64'(e_resp));
  endtask

  task automatic chk_req(input string tag, input xfer_t t, input logic [DW-1:0] e_pw);
    chk({tag, ".paddr"},  64'(paddr),  64'(t.a));
    chk({tag, ".pwrite"}, 64'(pwrite), 64'(t.w));
    chk({tag, ".pwdata"}, 64'(pwdata), 64'(e_pw));
  endtask

  task automatic drive_addr(input xfer_t t);
    hsel      = 1'b1;
    htrans    = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b10;
    haddr     = t.a;
    hwrite    = t.w;
    hready_in = 1'b1;
    hwdata    = $urandom;
  endtask

  task automatic drive_idle();
    hsel      = 1'($urandom);
    htrans    = 2'($urandom_range(0, 1));
    haddr     = $urandom;
    hwrite    = 1'($urandom);
    hready_in = 1'($urandom);
  endtask

  // Random address-phase traffic while the bridge is stalling; must be ignored.
  task automatic junk_addr();
    hsel      = 1'($urandom);
    htrans    = 2'($urandom);
    haddr     = $urandom;
    hwrite    = 1'($urandom);
    hready_in = 1'($urandom);
  endtask

  task automatic idle_cycle(input logic sel, input logic [1:0] tr);
    @(negedge hclk);
    chk_bus("idle", 0, 0, 1, 0);
    hsel = sel; htrans = tr; haddr = $urandom; hwrite = 1'($urandom); hready_in = 1'b1;
  endtask

  task automatic begin_xfer(input xfer_t t);
    @(negedge hclk);
    chk_bus("pre", 0, 0, 1, 0);
    drive_addr(t);
  endtask

  // Runs one transfer whose address phase is already on the bus. Ends in the
  // final response cycle having driven either the next address phase or idle.
  task automatic xfer(input xfer_t t, input bit nxt, input xfer_t n);
    logic [DW-1:0] e_pw;
    e_pw = t.w ? t.wd : last_wd;
    @(negedge hclk);
    chk_bus("latch", 0, 0, 0, 0);
    hwdata = t.w ? t.wd : DW'($urandom);
    junk_addr();
    @(negedge hclk);
    chk_bus("setup", 1, 0, 0, 0);
    chk_req("setup", t, e_pw);
    hwdata = $urandom;
    pready = 1'b0;
    for (int i = 0; i <= t.waits; i++) begin
      @(negedge hclk);
      chk_bus("access", 1, 1, 0, 0);
      chk_req("access", t, e_pw);
      pready  = (i == t.waits);
      pslverr = (i == t.waits) ? t.err : 1'($urandom);
      prdata  = (i == t.waits) ? t.rd : DW'($urandom);
      junk_addr();
    end
    if (t.w) last_wd = t.wd;
    @(negedge hclk);
    pready = 1'b0; pslverr = 1'b0; prdata = $urandom;
    if (t.err) begin
      chk_bus("err1", 0, 0, 0, 1);
      chk("err1.hrdata", 64'(hrdata), 64'(exp_hrdata));
      @(negedge hclk);
      chk_bus("err2", 0, 0, 1, 1);
    end else begin
      if (!t.w) exp_hrdata = t.rd;
      chk_bus("resp", 0, 0, 1, 0);
    end
    chk("hrdata", 64'(hrdata), 64'(exp_hrdata));
    if (nxt) drive_addr(n); else drive_idle();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    xfer_t t, u, q[$];
    bit    nx;

    // Reset: 200 ns low, bus driven with would-be accepts that must be ignored.
    hreset_n = 1'b0;
    hsel = 1'b1; htrans = 2'b10; haddr = 32'hFFFF_FFFC; hwrite = 1'b1; hready_in = 1'b1;
    hwdata = 32'hFFFF_FFFF; prdata = 32'hFFFF_FFFF; pready = 1'b1; pslverr = 1'b1;
    last_wd = '0; exp_hrdata = '0;
    repeat (10) begin
      @(negedge hclk);
      chk_bus("rst", 0, 0, 1, 0);
      chk("rst.paddr",  64'(paddr),  64'h0);
      chk("rst.pwrite", 64'(pwrite), 64'h0);
      chk("rst.pwdata", 64'(pwdata), 64'h0);
      chk("rst.hrdata", 64'(hrdata), 64'h0);
    end
    hsel = 1'b0; htrans = 2'b00; pready = 1'b0; pslverr = 1'b0;
    hreset_n = 1'b1;

    // Zero-wait write.
    t = '{a: 32'h0000_1004, w: 1'b1, wd: 32'hDEAD_BEEF, waits: 0, err: 1'b0, rd: 32'h0, b2b: 1'b0};
    begin_xfer(t);
    xfer(t, 0, t);

    // Read with three wait states.
    t = '{a: 32'h0000_2000, w: 1'b0, wd: 32'h0, waits: 3, err: 1'b0, rd: 32'h1234_5678, b2b: 1'b0};
    begin_xfer(t);
    xfer(t, 0, t);

    // Slave error on a write.
    t = '{a: 32'h0000_3008, w: 1'b1, wd: 32'hCAFE_0001, waits: 1, err: 1'b1, rd: 32'hAAAA_5555, b2b: 1'b0};
    begin_xfer(t);
    xfer(t, 0, t);
    idle_cycle(1'b0, 2'b10);

    // Two reads separated by IDLE and BUSY transfers.
    t = '{a: 32'h0000_4000, w: 1'b0, wd: 32'h0, waits: 0, err: 1'b0, rd: 32'h1111_2222, b2b: 1'b0};
    u = '{a: 32'h0000_4004, w: 1'b0, wd: 32'h0, waits: 2, err: 1'b0, rd: 32'h3333_4444, b2b: 1'b0};
    begin_xfer(t);
    xfer(t, 0, t);
    idle_cycle(1'b1, 2'b00);
    idle_cycle(1'b1, 2'b01);
    begin_xfer(u);
    xfer(u, 0, u);

    // Back-to-back reads, then an error followed directly by another read.
    t = '{a: 32'h0000_5000, w: 1'b0, wd: 32'h0, waits: 0, err: 1'b0, rd: 32'h5555_6666, b2b: 1'b0};
    u = '{a: 32'h0000_5010, w: 1'b0, wd: 32'h0, waits: 1, err: 1'b0, rd: 32'h7777_8888, b2b: 1'b1};
    begin_xfer(t);
    xfer(t, 1, u);
    t = '{a: 32'h0000_6000, w: 1'b0, wd: 32'h0, waits: 0, err: 1'b1, rd: 32'h9999_0000, b2b: 1'b1};
    xfer(u, 1, t);
    u = '{a: 32'h0000_6004, w: 1'b0, wd: 32'h0, waits: 0, err: 1'b0, rd: 32'hABCD_EF01, b2b: 1'b1};
    xfer(t, 1, u);
    xfer(u, 0, u);

    // Reset asserted in the middle of an ACCESS phase.
    t = '{a: 32'h0000_7000, w: 1'b1, wd: 32'h0BAD_F00D, waits: 0, err: 1'b0, rd: 32'h0, b2b: 1'b0};
    begin_xfer(t);
    @(negedge hclk);
    hwdata = t.wd; junk_addr();
    @(negedge hclk);
    pready = 1'b0;
    @(negedge hclk);
    chk_bus("mid.access", 1, 1, 0, 0);
    hreset_n = 1'b0;
    #1;
    chk_bus("mid.rst", 0, 0, 1, 0);
    chk("mid.paddr",  64'(paddr),  64'h0);
    chk("mid.pwdata", 64'(pwdata), 64'h0);
    chk("mid.hrdata", 64'(hrdata), 64'h0);
    last_wd = '0; exp_hrdata = '0;
    hsel = 1'b0; htrans = 2'b00;
    @(negedge hclk);
    hreset_n = 1'b1;

`ifdef AHB2APB_TIMEOUT_EN
    // Slave never answers: 16 ACCESS cycles, then a two-cycle ERROR response.
    t = '{a: 32'h0000_8000, w: 1'b0, wd: 32'h0, waits: 0, err: 1'b0, rd: 32'h0, b2b: 1'b0};
    begin_xfer(t);
    @(negedge hclk);
    chk_bus("to.latch", 0, 0, 0, 0);
    junk_addr();
    @(negedge hclk);
    chk_bus("to.setup", 1, 0, 0, 0);
    pready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge hclk);
      chk_bus("to.access", 1, 1, 0, 0);
      prdata = $urandom;
    end
    @(negedge hclk);
    chk_bus("to.err1", 0, 0, 0, 1);
    @(negedge hclk);
    chk_bus("to.err2", 0, 0, 1, 1);
    chk("to.hrdata", 64'(hrdata), 64'(exp_hrdata));
    drive_idle();
`endif

    // Randomized transfers, some chained back-to-back.
    for (int i = 0; i < 40; i++) begin
      t.a     = $urandom & 32'hFFFF_FFFC;
      t.w     = 1'($urandom);
      t.wd    = $urandom;
      t.waits = $urandom_range(0, 4);
      t.err   = ($urandom_range(0, 4) == 0);
      t.rd    = $urandom;
      t.b2b   = (i != 0) && 1'($urandom);
      q.push_back(t);
    end
    begin_xfer(q[0]);
    for (int i = 0; i < q.size(); i++) begin
      nx = (i + 1 < q.size()) && q[i+1].b2b;
      u  = (i + 1 < q.size()) ? q[i+1] : q[i];
      xfer(q[i], nx, u);
      if (!nx && i + 1 < q.size()) begin
        repeat ($urandom_range(0, 2)) idle_cycle(1'($urandom), 2'($urandom_range(0, 1)));
        begin_xfer(q[i+1]);
      end
    end
    idle_cycle(1'b0, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
